// File: rtl/regfile_wb_scheduler_if.sv
// Writeback request bus shared by all execution units feeding the register file write port.
// Requester i owns slice i of each packed field; wb_ready is the one-hot grant back to them.
interface regfile_wb_scheduler_if #(
    parameter int NREQ = 3,
    parameter int XLEN = 32
);
    logic [NREQ-1:0]      wb_valid;
    logic [5*NREQ-1:0]    wb_rd;
    logic [XLEN*NREQ-1:0] wb_data;
    logic [NREQ-1:0]      wb_ready;

    modport master (output wb_valid, output wb_rd, output wb_data, input wb_ready);
    modport slave  (input wb_valid, input wb_rd, input wb_data, output wb_ready);
endinterface

// File: rtl/regfile_wb_scheduler.sv
// Round-robin scheduler for the register file's single write port, plus a 32-entry
// scoreboard of in-flight destinations used by decode for RAW hazard detection.
module regfile_wb_scheduler #(
    parameter int NREQ = 3,
    parameter int XLEN = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    regfile_wb_scheduler_if.slave wb,
    output logic                  rf_we,
    output logic [4:0]            rf_rd,
    output logic [XLEN-1:0]       rf_wdata,
    input  logic                  iss_valid,
    input  logic [4:0]            iss_rd,
    output logic                  iss_ready,
    input  logic [4:0]            q_rs1,
    input  logic [4:0]            q_rs2,
    output logic                  rs1_busy,
    output logic                  rs2_busy,
    output logic [31:0]           busy_vec
);

    localparam int              PTR_W    = $clog2(NREQ);
    localparam logic [PTR_W:0]  NREQ_W   = (PTR_W+1)'(NREQ);
    localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(NREQ-1);

    logic [PTR_W-1:0] r_ptr;
    logic [PTR_W:0]   w_cand;
    logic [PTR_W-1:0] w_gnt_idx;
    logic             w_xfer;
    logic [NREQ-1:0]  w_gnt;
    logic [4:0]       w_sel_rd;
    logic [XLEN-1:0]  w_sel_data;

    logic             r_rf_we;
    logic [4:0]       r_rf_rd;
    logic [XLEN-1:0]  r_rf_wdata;
    logic [31:0]      r_busy;
    logic [31:0]      w_busy_nxt;
    logic             w_iss_fire;

    // Scan from the farthest candidate back to ptr so the last hit, i.e. the
    // first valid index at or after ptr, is the one that sticks.
    // NOTE: blocking assignments in always_comb; every output gets a default first so no latch is inferred.
    always_comb begin
        w_cand    = '0;
        w_xfer    = 1'b0;
        w_gnt_idx = '0;
        for (int k = NREQ-1; k >= 0; k--) begin
            w_cand = {1'b0, r_ptr} + (PTR_W+1)'(k);
            if (w_cand >= NREQ_W) w_cand = w_cand - NREQ_W;
            if (wb.wb_valid[w_cand[PTR_W-1:0]]) begin
                w_xfer    = 1'b1;
                w_gnt_idx = w_cand[PTR_W-1:0];
            end
        end
    end

    always_comb begin
        w_gnt = '0;
        if (w_xfer) w_gnt[w_gnt_idx] = 1'b1;
    end

    assign wb.wb_ready = w_gnt;
    assign w_sel_rd    = wb.wb_rd[5*w_gnt_idx +: 5];
    assign w_sel_data  = wb.wb_data[XLEN*w_gnt_idx +: XLEN];

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr <= '0;
        end else if (w_xfer) begin
            r_ptr <= (w_gnt_idx == LAST_IDX) ? '0 : w_gnt_idx + 1'b1;
        end
    end

    // rd==0 writebacks complete the handshake but never strobe the write port.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rf_we    <= 1'b0;
            r_rf_rd    <= '0;
            r_rf_wdata <= '0;
        end else begin
            r_rf_we <= w_xfer && (w_sel_rd != 5'd0);
            if (w_xfer) begin
                r_rf_rd    <= w_sel_rd;
                r_rf_wdata <= w_sel_data;
            end
        end
    end

    assign iss_ready  = (iss_rd == 5'd0) || !r_busy[iss_rd];
    assign w_iss_fire = iss_valid && iss_ready && (iss_rd != 5'd0);

    // Set is applied after clear: a same-index collision leaves the new writer busy.
    always_comb begin
        w_busy_nxt = r_busy;
        if (r_rf_we)    w_busy_nxt[r_rf_rd] = 1'b0;
        if (w_iss_fire) w_busy_nxt[iss_rd]  = 1'b1;
        w_busy_nxt[0] = 1'b0;
    end

    // NOTE: the scoreboard is a flop vector, not RAM, so it is reset like any other state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_busy <= '0;
        else        r_busy <= w_busy_nxt;
    end

    assign rf_we    = r_rf_we;
    assign rf_rd    = r_rf_rd;
    assign rf_wdata = r_rf_wdata;
    assign busy_vec = r_busy;
    assign rs1_busy = r_busy[q_rs1];
    assign rs2_busy = r_busy[q_rs2];

endmodule

// File: tb/tb_regfile_wb_scheduler.sv
// Directed bench for regfile_wb_scheduler: expected register-file writes go into a queue,
// a negedge monitor pops them as rf_we fires; handshake and scoreboard state are checked inline.
module tb_regfile_wb_scheduler;

    localparam int NREQ = 3;
    localparam int XLEN = 32;

    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] data;
    } wr_t;

    logic        clk;
    logic        rst_n;
    logic        rf_we;
    logic [4:0]  rf_rd;
    logic [31:0] rf_wdata;
    logic        iss_valid;
    logic [4:0]  iss_rd;
    logic        iss_ready;
    logic [4:0]  q_rs1;
    logic [4:0]  q_rs2;
    logic        rs1_busy;
    logic        rs2_busy;
    logic [31:0] busy_vec;

    wr_t exp_q[$];
    int  n_pass  = 0;
    int  n_total = 0;

    regfile_wb_scheduler_if #(.NREQ(NREQ), .XLEN(XLEN)) wbif ();

    regfile_wb_scheduler #(.NREQ(NREQ), .XLEN(XLEN)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .wb        (wbif.slave),
        .rf_we     (rf_we),
        .rf_rd     (rf_rd),
        .rf_wdata  (rf_wdata),
        .iss_valid (iss_valid),
        .iss_rd    (iss_rd),
        .iss_ready (iss_ready),
        .q_rs1     (q_rs1),
        .q_rs2     (q_rs2),
        .rs1_busy  (rs1_busy),
        .rs2_busy  (rs2_busy),
        .busy_vec  (busy_vec)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [4:0] rd, input logic [31:0] d);
        wbif.wb_rd[5*i +: 5]     = rd;
        wbif.wb_data[32*i +: 32] = d;
    endtask

    task automatic expect_wr(input logic [4:0] rd, input logic [31:0] d);
        wr_t w;
        w.rd   = rd;
        w.data = d;
        exp_q.push_back(w);
    endtask

    always @(negedge clk) begin
        if (rst_n && rf_we) begin
            if (exp_q.size() == 0) begin
                check("unexpected_rf_we", 64'(rf_we), 64'd0);
            end else begin
                wr_t w;
                w = exp_q.pop_front();
                check("rf_rd", 64'(rf_rd), 64'(w.rd));
                check("rf_wdata", 64'(rf_wdata), 64'(w.data));
            end
        end
    end

    initial begin
        logic [2:0] rr_gnt [4];
        rr_gnt = '{3'b001, 3'b010, 3'b100, 3'b001};

        // Reset with every input active
        rst_n          = 1'b0;
        wbif.wb_valid  = 3'b111;
        wbif.wb_rd     = '0;
        wbif.wb_data   = '0;
        set_req(0, 5'd1, 32'hA);
        set_req(1, 5'd2, 32'hB);
        set_req(2, 5'd3, 32'hC);
        iss_valid = 1'b1;
        iss_rd    = 5'd4;
        q_rs1     = 5'd0;
        q_rs2     = 5'd0;
        repeat (3) tick();
        check("reset_rf_we", 64'(rf_we), 64'd0);
        check("reset_rf_rd", 64'(rf_rd), 64'd0);
        check("reset_rf_wdata", 64'(rf_wdata), 64'd0);
        check("reset_busy_vec", 64'(busy_vec), 64'd0);
        check("reset_wb_ready", 64'(wbif.wb_ready), 64'(3'b001));
        iss_valid = 1'b0;
        rst_n     = 1'b1;
        #1;

        // Round-robin with all three continuously valid
        expect_wr(5'd1, 32'hA);
        expect_wr(5'd2, 32'hB);
        expect_wr(5'd3, 32'hC);
        expect_wr(5'd1, 32'hA);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("rr_grant_%0d", i), 64'(wbif.wb_ready), 64'(rr_gnt[i]));
            tick();
        end
        wbif.wb_valid = 3'b000;
        #1;

        // Lone requester 2 (ptr=1)
        set_req(2, 5'd5, 32'hDEADBEEF);
        wbif.wb_valid = 3'b100;
        #1;
        check("lone_req2_ready", 64'(wbif.wb_ready), 64'(3'b100));
        expect_wr(5'd5, 32'hDEADBEEF);
        tick();
        wbif.wb_valid = 3'b000;
        check("lone_rf_we", 64'(rf_we), 64'd1);
        check("lone_rf_rd", 64'(rf_rd), 64'd5);
        check("lone_rf_wdata", 64'(rf_wdata), 64'hDEADBEEF);
        tick();
        check("idle_rf_we", 64'(rf_we), 64'd0);
        check("idle_rf_rd_hold", 64'(rf_rd), 64'd5);
        check("idle_rf_wdata_hold", 64'(rf_wdata), 64'hDEADBEEF);

        // Requesters 0 and 2 contend (ptr=0): 0 first, 2 holds and goes next
        set_req(0, 5'd10, 32'h10);
        set_req(2, 5'd11, 32'h11);
        wbif.wb_valid = 3'b101;
        #1;
        check("contend_first", 64'(wbif.wb_ready), 64'(3'b001));
        expect_wr(5'd10, 32'h10);
        expect_wr(5'd11, 32'h11);
        tick();
        wbif.wb_valid = 3'b100;
        #1;
        check("contend_second", 64'(wbif.wb_ready), 64'(3'b100));
        tick();
        wbif.wb_valid = 3'b000;
        #1;

        // Scoreboard lifecycle on rd=7 (ptr=0)
        iss_valid = 1'b1;
        iss_rd    = 5'd7;
        #1;
        check("iss7_ready", 64'(iss_ready), 64'd1);
        tick();
        check("busy7_set", 64'(busy_vec), 64'(32'h80));
        check("iss7_blocked", 64'(iss_ready), 64'd0);
        q_rs1 = 5'd7;
        q_rs2 = 5'd0;
        set_req(1, 5'd7, 32'h77);
        wbif.wb_valid = 3'b010;
        #1;
        check("rs1_busy_N", 64'(rs1_busy), 64'd1);
        check("rs2_busy_r0", 64'(rs2_busy), 64'd0);
        check("wb7_ready", 64'(wbif.wb_ready), 64'(3'b010));
        expect_wr(5'd7, 32'h77);
        tick();
        wbif.wb_valid = 3'b000;
        #1;
        check("rs1_busy_N1", 64'(rs1_busy), 64'd1);
        tick();
        iss_valid = 1'b0;
        #1;
        check("rs1_busy_N2", 64'(rs1_busy), 64'd0);
        check("busy7_clear", 64'(busy_vec), 64'd0);

        // Stray writeback to rd=9 collides with an issue to rd=9 (ptr=2)
        set_req(0, 5'd9, 32'h99);
        wbif.wb_valid = 3'b001;
        #1;
        check("wrap_ready", 64'(wbif.wb_ready), 64'(3'b001));
        expect_wr(5'd9, 32'h99);
        tick();
        wbif.wb_valid = 3'b000;
        iss_valid     = 1'b1;
        iss_rd        = 5'd9;
        #1;
        check("collide_iss_ready", 64'(iss_ready), 64'd1);
        tick();
        iss_valid = 1'b0;
        #1;
        check("collide_busy9", 64'(busy_vec), 64'(32'h200));
        set_req(1, 5'd9, 32'h9A);
        wbif.wb_valid = 3'b010;
        #1;
        check("wb9_ready", 64'(wbif.wb_ready), 64'(3'b010));
        expect_wr(5'd9, 32'h9A);
        tick();
        wbif.wb_valid = 3'b000;
        tick();
        check("busy9_clear", 64'(busy_vec), 64'd0);

        // rd=0 writeback (ptr=2): accepted, no write strobe, pointer advances
        set_req(2, 5'd0, 32'h5555);
        wbif.wb_valid = 3'b100;
        #1;
        check("rd0_ready", 64'(wbif.wb_ready), 64'(3'b100));
        tick();
        wbif.wb_valid = 3'b000;
        check("rd0_rf_we", 64'(rf_we), 64'd0);
        check("rd0_busy_vec", 64'(busy_vec), 64'd0);

        // Reset mid-flight (ptr=0 after the rd=0 transfer)
        set_req(1, 5'd12, 32'hC0FFEE);
        set_req(2, 5'd13, 32'h1313);
        wbif.wb_valid = 3'b110;
        iss_valid     = 1'b1;
        iss_rd        = 5'd20;
        #1;
        check("ptr_after_rd0", 64'(wbif.wb_ready), 64'(3'b010));
        tick();
        wbif.wb_valid = 3'b000;
        iss_valid     = 1'b0;
        check("mid_rf_we", 64'(rf_we), 64'd1);
        check("mid_busy20", 64'(busy_vec), 64'(32'h0010_0000));
        #1;
        rst_n = 1'b0;
        #1;
        check("async_rf_we", 64'(rf_we), 64'd0);
        check("async_busy_vec", 64'(busy_vec), 64'd0);
        check("async_rf_rd", 64'(rf_rd), 64'd0);
        wbif.wb_valid = 3'b100;
        #1;
        check("reset_ptr_rr", 64'(wbif.wb_ready), 64'(3'b100));
        wbif.wb_valid = 3'b000;
        tick();
        rst_n = 1'b1;
        repeat (3) tick();
        check("scoreboard_drained", 64'(exp_q.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/regfile_wb_scheduler.md
# regfile_wb_scheduler

Schedules the register file's single write port among `NREQ` writeback requesters (ALU, load unit, multiply/divide, …) using round-robin arbitration. Tracks in-flight destination registers in a 32-entry scoreboard so decode can detect read-after-write hazards. Sits between the execution units and the register file's write port. Supplies `write_enable`/`rd`/`write_data` one cycle after acceptance and busy flags for `rs1`/`rs2`.

## Interface
Parameters:
- `NREQ`, default 3: number of writeback requesters; legal range 2..8.
- `XLEN`, default 32: data width.

Ports:
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `wb_valid`  in  NREQ  per-requester writeback request.
- `wb_rd`  in  5*NREQ  destination index; requester i uses bits [5i+4:5i].
- `wb_data`  in  XLEN*NREQ  write data; requester i uses bits [XLEN*i+XLEN-1:XLEN*i].
- `wb_ready`  out  NREQ  one-hot grant; transfer occurs when `wb_valid[i] & wb_ready[i]`.
- `rf_we`  out  1  registered write enable to the register file.
- `rf_rd`  out  5  registered write address.
- `rf_wdata`  out  XLEN  registered write data.
- `iss_valid`  in  1  decode issuing an instruction that writes `iss_rd`.
- `iss_rd`  in  5  destination of the issuing instruction.
- `iss_ready`  out  1  issue may proceed; high when `iss_rd`==0 or `busy[iss_rd]`==0.
- `q_rs1`, `q_rs2`  in  5 each  hazard query indices.
- `rs1_busy`, `rs2_busy`  out  1 each  combinational `busy[q_rsX]`; always 0 for index 0.
- `busy_vec`  out  32  full scoreboard; bit 0 always 0.

## Operation
- **Arbitration.** Round-robin over `wb_valid` with pointer `ptr` (0..NREQ-1).
  - Grant goes to the first valid index at or after `ptr`, wrapping modulo NREQ.
  - `wb_ready` is combinational from `wb_valid` and `ptr`; at most one bit is high, and only for a valid requester.
  - After a transfer to index g, `ptr` becomes (g+1) mod NREQ. With no transfer, `ptr` holds.
- **Requester rule.** A requester holds `wb_valid`, `wb_rd` and `wb_data` stable until accepted. Dropping valid before acceptance is a protocol violation.
- **Worst-case wait.** A continuously valid requester waits at most NREQ-1 grants.
- **Write port.** On a transfer:
  - `rf_we` is 1 next cycle, with `rf_rd`/`rf_wdata` equal to the granted `wb_rd`/`wb_data`.
  - With no transfer, `rf_we`=0 and `rf_rd`/`rf_wdata` hold their last values.
- **rd = 0 writebacks.** A transfer with `wb_rd`==0 is accepted normally (handshake completes, pointer advances), but `rf_we` stays 0.
- **Scoreboard set.** `iss_valid & iss_ready & iss_rd!=0` sets `busy[iss_rd]`.
  - `iss_valid` with `iss_ready`=0 has no effect; decode must stall.
  - Result: at most one outstanding writer per register, so WAW hazards never reach the write port.
- **Scoreboard clear.** `rf_we`=1 clears `busy[rf_rd]` on the same edge that the register file captures the write.
- **Simultaneous set and clear, same index.** Set wins, and `busy` remains 1. This is legal because the clear belongs to the old writer and `iss_ready` was computed before the edge.
- **Stray writebacks.** A writeback to a non-busy rd is still performed; the scoreboard clear is then a no-op.

## Timing
- **Reset values.** While `rst_n`=0, asynchronously: `ptr`=0, `busy_vec`=0, `rf_we`=0, `rf_rd`=0, `rf_wdata`=0.
  - `wb_ready` follows the combinational rule with `ptr`=0.
  - Reset asserted mid-operation discards any pending `rf_we` and all busy bits.
- **Writeback latency.** Accept in cycle N → `rf_we` high in N+1 → register file updated at end of N+1.
  - Cycle N+2: an async read returns the new value and `busy`=0.
  - This gives 2 cycles from acceptance to a hazard-free read.
- **Throughput.** One writeback per cycle sustained. Back-to-back grants to the same requester are allowed when it is the only valid one.
- **Issue to hazard flag.** Issue accepted in cycle N → `busy` visible in cycle N+1.
- **Combinational paths.**
  - `wb_valid` → `wb_ready`.
  - `iss_rd`, `busy` → `iss_ready`.
  - `q_rsX` → `rsX_busy`.
  - No combinational path from `wb_*` to `rf_*`.

## Test plan
- **Reset.** Assert `rst_n`=0 with all inputs active → `rf_we`=0, `busy_vec`=0. First grant after release with all valid goes to index 0.
- **Round-robin fairness.** All three valid continuously, with rd=1/2/3 and data 0xA/0xB/0xC → grants 0,1,2,0,… and `rf_rd` sequence 1,2,3,1 on consecutive cycles with matching data.
- **Hold until accepted.** Requester 2 alone valid, rd=5, data 0xDEADBEEF → `wb_ready`=3'b100 same cycle. Next cycle `rf_we`=1, `rf_rd`=5, `rf_wdata`=0xDEADBEEF.
- **Scoreboard lifecycle.**
  - Issue rd=7 → `busy_vec[7]`=1 and `iss_ready`=0 for a second issue to rd=7.
  - Writeback rd=7 accepted in cycle N → `busy_vec[7]`=0 in N+2.
  - Querying `q_rs1`=7 gives `rs1_busy`=1 through N+1 and 0 in N+2.
- **Set/clear collision and rd = 0.**
  - Issue to rd=9 on the same edge as `rf_we` for rd=9 → `busy[9]` stays 1.
  - Writeback with rd=0 → handshake completes, `rf_we`=0, `busy_vec`=0.
- **Reset mid-flight.** Accept a writeback, then assert `rst_n`=0 in the following cycle → `rf_we` drops immediately (asynchronously) and all busy bits clear.
